// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction codes, ALU
// functions, condition codes and condition-code bit positions.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_XOR = 2'd3
   } alufun_e;

   localparam logic [3:0] C_YES = 4'd0;
   localparam logic [3:0] C_LE  = 4'd1;
   localparam logic [3:0] C_L   = 4'd2;
   localparam logic [3:0] C_E   = 4'd3;
   localparam logic [3:0] C_NE  = 4'd4;
   localparam logic [3:0] C_GE  = 4'd5;
   localparam logic [3:0] C_G   = 4'd6;

   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/y86_alu.sv
// Combinational 64-bit ALU: result = alu_b op alu_a, plus ZF/SF/OF.
module y86_alu
   import y86_pkg::*;
(
   input  logic [63:0] alu_a,
   input  logic [63:0] alu_b,
   input  alufun_e     alufun,
   output logic [63:0] result,
   output logic        zf,
   output logic        sf,
   output logic        of
);

   always_comb begin
      result = alu_b + alu_a;
      of     = 1'b0;
      case (alufun)
         ALU_ADD: begin
            result = alu_b + alu_a;
            of     = (alu_a[63] == alu_b[63]) && (result[63] != alu_a[63]);
         end
         ALU_SUB: begin
            result = alu_b - alu_a;
            of     = (alu_a[63] != alu_b[63]) && (result[63] != alu_b[63]);
         end
         ALU_AND: result = alu_b & alu_a;
         ALU_XOR: result = alu_b ^ alu_a;
         default: result = alu_b + alu_a;
      endcase
      zf = (result == 64'd0);
      sf = result[63];
   end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition evaluation, cc register
// and a single-entry valid/ready output register toward memory/writeback.
module execute_stage
   import y86_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  icode,
   input  logic [3:0]  ifun,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic [63:0] valA,
   input  logic [63:0] valB,
   input  logic [63:0] valC,
   input  logic [63:0] valP,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  e_icode,
   output logic [3:0]  e_rA,
   output logic [3:0]  e_rB,
   output logic [63:0] e_valA,
   output logic [63:0] e_valP,
   output logic [63:0] e_valE,
   output logic        e_cnd,
   output logic        e_err,
   output logic [2:0]  cc,
   output logic        halted
);

   logic [63:0] alu_a, alu_b, alu_result;
   alufun_e     alufun;
   logic        alu_zf, alu_sf, alu_of;
   logic        err, cnd, accept;

   always_comb begin
      alu_a = 64'd0;
      alu_b = 64'd0;
      case (icode)
         I_RRMOVQ, I_OPQ:            alu_a = valA;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = valC;
         I_CALL, I_PUSHQ:            alu_a = -64'sd8;
         I_RET, I_POPQ:              alu_a = 64'd8;
         default:                    alu_a = 64'd0;
      endcase
      case (icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = valB;
         default: alu_b = 64'd0;
      endcase
   end

   assign alufun = (icode == I_OPQ) ? alufun_e'(ifun[1:0]) : ALU_ADD;

   y86_alu u_alu (
      .alu_a  (alu_a),
      .alu_b  (alu_b),
      .alufun (alufun),
      .result (alu_result),
      .zf     (alu_zf),
      .sf     (alu_sf),
      .of     (alu_of)
   );

   assign err = (icode > I_POPQ)
             || (icode == I_OPQ && ifun > 4'd3)
             || ((icode == I_RRMOVQ || icode == I_JXX) && ifun > C_G);

   // Conditions use the registered cc, so an OPq accepted last cycle is already visible.
   always_comb begin
      logic lt;
      lt  = cc[CC_SF] ^ cc[CC_OF];
      cnd = 1'b0;
      if ((icode == I_RRMOVQ || icode == I_JXX) && !err) begin
         case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | cc[CC_ZF];
            C_L:     cnd = lt;
            C_E:     cnd = cc[CC_ZF];
            C_NE:    cnd = ~cc[CC_ZF];
            C_GE:    cnd = ~lt;
            C_G:     cnd = ~lt & ~cc[CC_ZF];
            default: cnd = 1'b0;
         endcase
      end
   end

   assign in_ready = reset_n & ~halted & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         halted    <= 1'b0;
         cc        <= CC_RESET;
         e_icode   <= 4'd0;
         e_rA      <= 4'd0;
         e_rB      <= 4'd0;
         e_valA    <= 64'd0;
         e_valP    <= 64'd0;
         e_valE    <= 64'd0;
         e_cnd     <= 1'b0;
         e_err     <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         e_icode   <= icode;
         e_rA      <= rA;
         e_rB      <= rB;
         e_valA    <= valA;
         e_valP    <= valP;
         e_valE    <= err ? 64'd0 : alu_result;
         e_cnd     <= cnd;
         e_err     <= err;
         if (icode == I_OPQ && !err)
            cc <= {alu_zf, alu_sf, alu_of};
         if (icode == I_HALT || err)
            halted <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios followed by random
// traffic, all checked against an arithmetic reference model of the stage.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        reset_n, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valA, valB, valC, valP;
   logic [3:0]  e_icode, e_rA, e_rB;
   logic [63:0] e_valA, e_valP, e_valE;
   logic        e_cnd, e_err, halted;
   logic [2:0]  cc;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic        m_ov, m_halted, m_cnd, m_err;
   logic [2:0]  m_cc;
   logic [3:0]  m_icode, m_rA, m_rB;
   logic [63:0] m_valA, m_valP, m_valE;

   always #5 clk = ~clk;

   execute_stage dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
      .valA(valA), .valB(valB), .valC(valC), .valP(valP),
      .out_valid(out_valid), .out_ready(out_ready),
      .e_icode(e_icode), .e_rA(e_rA), .e_rB(e_rB), .e_valA(e_valA), .e_valP(e_valP),
      .e_valE(e_valE), .e_cnd(e_cnd), .e_err(e_err), .cc(cc), .halted(halted)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] c);
      logic zf, sf, of, lt;
      zf = c[2]; sf = c[1]; of = c[0];
      lt = sf ^ of;
      case (fn)
         4'd0: return 1'b1;
         4'd1: return lt || zf;
         4'd2: return lt;
         4'd3: return zf;
         4'd4: return !zf;
         4'd5: return !lt;
         4'd6: return !lt && !zf;
         default: return 1'b0;
      endcase
   endfunction

   // Behaviour of one instruction in terms of what it computes, not how.
   task automatic ref_exec(input logic [3:0] ic, input logic [3:0] fn,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                           input logic [2:0] cc_in,
                           output logic [63:0] ve, output logic cn, output logic er,
                           output logic [2:0] cc_out);
      logic signed [64:0] wide;
      logic               of;
      ve = 64'd0; cn = 1'b0; cc_out = cc_in; of = 1'b0;
      er = (ic > 4'd11) || (ic == 4'd6 && fn > 4'd3) || ((ic == 4'd2 || ic == 4'd7) && fn > 4'd6);
      if (!er) begin
         case (ic)
            4'd2:        begin ve = a; cn = cond_eval(fn, cc_in); end
            4'd3:        ve = c;
            4'd4, 4'd5:  ve = b + c;
            4'd7:        cn = cond_eval(fn, cc_in);
            4'd8, 4'd10: ve = b - 64'd8;
            4'd9, 4'd11: ve = b + 64'd8;
            4'd6: begin
               case (fn)
                  4'd0: begin
                     wide = $signed({b[63], b}) + $signed({a[63], a});
                     ve = wide[63:0]; of = wide[64] != wide[63];
                  end
                  4'd1: begin
                     wide = $signed({b[63], b}) - $signed({a[63], a});
                     ve = wide[63:0]; of = wide[64] != wide[63];
                  end
                  4'd2: ve = a & b;
                  default: ve = a ^ b;
               endcase
               cc_out = {ve == 64'd0, ve[63], of};
            end
            default: ve = 64'd0;
         endcase
      end
   endtask

   task automatic set_in(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
      in_valid = v; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
      rA = 4'($urandom_range(0, 15)); rB = 4'($urandom_range(0, 15));
      valP = {$urandom, $urandom};
   endtask

   // One clock: check in_ready before the edge, advance the model, check after it.
   task automatic cycle();
      logic        exp_rdy, acc, cn, er;
      logic [63:0] ve;
      logic [2:0]  ncc;
      #1;
      exp_rdy = reset_n && !m_halted && (!m_ov || out_ready);
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      acc = in_valid && exp_rdy;
      if (!reset_n) begin
         m_ov = 0; m_halted = 0; m_cc = 3'b100; m_icode = 0; m_rA = 0; m_rB = 0;
         m_valA = 0; m_valP = 0; m_valE = 0; m_cnd = 0; m_err = 0;
      end else if (acc) begin
         ref_exec(icode, ifun, valA, valB, valC, m_cc, ve, cn, er, ncc);
         m_ov = 1; m_icode = icode; m_rA = rA; m_rB = rB; m_valA = valA; m_valP = valP;
         m_valE = ve; m_cnd = cn; m_err = er; m_cc = ncc;
         if (icode == 4'd0 || er) m_halted = 1;
      end else if (out_ready) begin
         m_ov = 0;
      end
      @(posedge clk);
      #1;
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
      chk("halted", {63'd0, halted}, {63'd0, m_halted});
      chk("cc", {61'd0, cc}, {61'd0, m_cc});
      chk("e_icode", {60'd0, e_icode}, {60'd0, m_icode});
      chk("e_rA", {60'd0, e_rA}, {60'd0, m_rA});
      chk("e_rB", {60'd0, e_rB}, {60'd0, m_rB});
      chk("e_valA", e_valA, m_valA);
      chk("e_valP", e_valP, m_valP);
      chk("e_valE", e_valE, m_valE);
      chk("e_cnd", {63'd0, e_cnd}, {63'd0, m_cnd});
      chk("e_err", {63'd0, e_err}, {63'd0, m_err});
   endtask

   initial begin
      m_ov = 0; m_halted = 0; m_cc = 3'b100; m_icode = 0; m_rA = 0; m_rB = 0;
      m_valA = 0; m_valP = 0; m_valE = 0; m_cnd = 0; m_err = 0;
      reset_n = 0; out_ready = 1;
      set_in(1, 4'd6, 4'd0, 64'd1, 64'd1, 64'd0);
      @(negedge clk);
      cycle();
      cycle();
      chk("rst_cc", {61'd0, cc}, 64'd4);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);

      // OPq add overflowing into the sign bit
      reset_n = 1;
      set_in(1, 4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
      cycle();
      chk("add_valE", e_valE, 64'h8000_0000_0000_0000);
      chk("add_cc", {61'd0, cc}, 64'b011);

      // subq then jl / jge using the freshly written cc
      set_in(1, 4'd6, 4'd1, 64'd5, 64'd3, 64'd0);
      cycle();
      chk("sub_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("sub_cc", {61'd0, cc}, 64'b010);
      set_in(1, 4'd7, 4'd2, 64'd0, 64'd0, 64'h40);
      cycle();
      chk("jl_cnd", {63'd0, e_cnd}, 64'd1);
      set_in(1, 4'd7, 4'd5, 64'd0, 64'd0, 64'h40);
      cycle();
      chk("jge_cnd", {63'd0, e_cnd}, 64'd0);

      // pushq under backpressure
      set_in(1, 4'd10, 4'd0, 64'h55, 64'h100, 64'd0);
      cycle();
      chk("push_valE", e_valE, 64'hF8);
      out_ready = 0;
      set_in(1, 4'd1, 4'd0, 64'd0, 64'd0, 64'd0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_hold_valE", e_valE, 64'hF8);
         chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1;
      cycle();
      chk("bp_accept_icode", {60'd0, e_icode}, 64'd1);
      chk("bp_accept_valid", {63'd0, out_valid}, 64'd1);

      // illegal icode halts the stage and leaves cc alone
      set_in(1, 4'hC, 4'd0, 64'd9, 64'd9, 64'd9);
      cycle();
      chk("err_flag", {63'd0, e_err}, 64'd1);
      chk("err_valE", e_valE, 64'd0);
      chk("err_halted", {63'd0, halted}, 64'd1);
      chk("err_cc", {61'd0, cc}, 64'b010);
      set_in(1, 4'd3, 4'd0, 64'd0, 64'd0, 64'd7);
      cycle();
      chk("halt_in_ready", {63'd0, in_ready}, 64'd0);

      // reset while a result is stalled in the output register
      reset_n = 0;
      cycle();
      reset_n = 1;
      out_ready = 0;
      set_in(1, 4'd6, 4'd1, 64'd5, 64'd3, 64'd0);
      cycle();
      chk("pre_rst_cc", {61'd0, cc}, 64'b010);
      reset_n = 0;
      cycle();
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_cc", {61'd0, cc}, 64'b100);
      chk("mid_rst_halted", {63'd0, halted}, 64'd0);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         int          r;
         logic [3:0]  ic, fn;
         logic [63:0] a, b;
         reset_n   = ($urandom_range(0, 29) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 59);
         if (r == 0)      ic = 4'($urandom_range(12, 15));
         else if (r == 1) ic = 4'd0;
         else             ic = 4'($urandom_range(1, 11));
         if (ic == 4'd6)                     fn = 4'((r == 2) ? $urandom_range(4, 15) : $urandom_range(0, 3));
         else if (ic == 4'd2 || ic == 4'd7)  fn = 4'((r == 3) ? $urandom_range(7, 15) : $urandom_range(0, 6));
         else                                fn = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0:       a = 64'h7FFF_FFFF_FFFF_FFFF;
            1:       a = 64'h8000_0000_0000_0000;
            default: a = {$urandom, $urandom};
         endcase
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = 64'($urandom_range(0, 3));
            default: b = {$urandom, $urandom};
         endcase
         set_in($urandom_range(0, 3) != 0, ic, fn, a, b, {$urandom, $urandom});
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
